fwd_hazard_unit: RTL and testbench

- Control-side producer for the EX-stage 3:1 operand muxes (sel 0 = register-file value, 1 = EX/MEM ALU result, 2 = MEM/WB writeback value).
- Shadows the destination-register pipeline of the 5-stage MIPS core.
- Issues registered forward selects for the instruction entering EX and a combinational load-use stall to IF/ID.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/fwd_hazard_unit.sv | 114 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use stall control for the 5-stage core.
// It shadows the destination-register pipeline and registers the mux selects so they line up with EX.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              stall,
    output logic              ex_bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    // WB needs no shadow: its value is already in the write-first regfile by the time a consumer reads.
    logic              ex_valid_r, ex_regwrite_r, ex_memread_r;
    logic [REG_AW-1:0] ex_dst_r;
    logic              mem_valid_r, mem_regwrite_r;
    logic [REG_AW-1:0] mem_dst_r;
    logic [1:0]        sel_a_r, sel_b_r;
    logic              ex_bubble_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              hz_s, stall_s, advance_s;
    logic [1:0]        sel_a_s, sel_b_s;

    function automatic logic produces(input logic v, input logic rw,
                                      input logic [REG_AW-1:0] dst,
                                      input logic [REG_AW-1:0] r);
        produces = v & rw & (dst == r) & (r != {REG_AW{1'b0}});
    endfunction

    function automatic logic [1:0] pick_sel(input logic used, input logic [REG_AW-1:0] r,
                                            input logic exv, input logic exrw,
                                            input logic [REG_AW-1:0] exd,
                                            input logic memv, input logic memrw,
                                            input logic [REG_AW-1:0] memd);
        if (!used)
            pick_sel = 2'd0;
        else if (produces(exv, exrw, exd, r))
            pick_sel = 2'd1;
        else if (produces(memv, memrw, memd, r))
            pick_sel = 2'd2;
        else
            pick_sel = 2'd0;
    endfunction

    // Load-use detection, stall generation and next-cycle select computation.
    always_comb begin
        hz_s = id_valid & ex_valid_r & ex_memread_r & ex_regwrite_r
             & (ex_dst_r != {REG_AW{1'b0}})
             & ((id_use_rs & (id_rs == ex_dst_r)) | (id_use_rt & (id_rt == ex_dst_r)));
        stall_s   = hz_s & ~flush;
        advance_s = id_valid & ~stall_s & ~flush;
        if (advance_s) begin
            sel_a_s = pick_sel(id_use_rs, id_rs, ex_valid_r, ex_regwrite_r, ex_dst_r,
                               mem_valid_r, mem_regwrite_r, mem_dst_r);
            sel_b_s = pick_sel(id_use_rt, id_rt, ex_valid_r, ex_regwrite_r, ex_dst_r,
                               mem_valid_r, mem_regwrite_r, mem_dst_r);
        end else begin
            sel_a_s = 2'd0;
            sel_b_s = 2'd0;
        end
    end

    // Shadow pipeline advance, registered selects and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r     <= 1'b0;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            ex_dst_r       <= {REG_AW{1'b0}};
            mem_valid_r    <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_dst_r      <= {REG_AW{1'b0}};
            sel_a_r        <= 2'd0;
            sel_b_r        <= 2'd0;
            ex_bubble_r    <= 1'b1;
            stall_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            mem_valid_r    <= ex_valid_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_dst_r      <= ex_dst_r;
            ex_valid_r     <= advance_s;
            ex_regwrite_r  <= id_regwrite;
            ex_memread_r   <= id_memread;
            ex_dst_r       <= id_dst;
            sel_a_r        <= sel_a_s;
            sel_b_r        <= sel_b_s;
            ex_bubble_r    <= ~advance_s;
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}}))
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            else
                stall_cnt_r <= stall_cnt_r;
        end
    end

    assign sel_a     = sel_a_r;
    assign sel_b     = sel_b_r;
    assign stall     = stall_s;
    assign ex_bubble = ex_bubble_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations.
// The counter is built 2 bits wide so saturation is reachable in a few stalls.
module tb_fwd_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
    logic [REG_AW-1:0] id_rs, id_rt, id_dst;
    logic [1:0]        sel_a, sel_b;
    logic              stall, ex_bubble;
    logic [CNT_W-1:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .ex_bubble(ex_bubble),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in ID (flush low) and let the combinational stall settle.
    task automatic issue(input int rs, input int rt, input logic urs, input logic urt,
                         input int dst, input logic rw, input logic mr);
        id_valid = 1'b1; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
        id_use_rs = urs; id_use_rt = urt; id_dst = REG_AW'(dst);
        id_regwrite = rw; id_memread = mr; flush = 1'b0;
        #1;
    endtask

    task automatic nop();
        id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        nop();
        tick(); tick();
        rst = 1'b0;
        chk("rst_sel_a", 32'(sel_a), 32'd0);
        chk("rst_sel_b", 32'(sel_b), 32'd0);
        chk("rst_bubble", 32'(ex_bubble), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);

        // ALU back-to-back: add $3 then sub reading $3 as rs.
        issue(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        chk("t1_stall_add", 32'(stall), 32'd0);
        tick();
        issue(3, 4, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        chk("t1_stall_sub", 32'(stall), 32'd0);
        tick();
        chk("t1_sel_a", 32'(sel_a), 32'd1);
        chk("t1_sel_b", 32'(sel_b), 32'd0);
        chk("t1_bubble", 32'(ex_bubble), 32'd0);
        chk("t1_cnt", 32'(stall_cnt), 32'd0);

        // Distance 2 then distance 3 on $5 as rt.
        issue(1, 1, 1'b1, 1'b1, 5, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        chk("t2_nop_bubble", 32'(ex_bubble), 32'd1);
        chk("t2_nop_sel_a", 32'(sel_a), 32'd0);
        issue(7, 5, 1'b1, 1'b1, 10, 1'b1, 1'b0);
        tick();
        chk("t2_d2_sel_b", 32'(sel_b), 32'd2);
        chk("t2_d2_sel_a", 32'(sel_a), 32'd0);
        issue(1, 5, 1'b1, 1'b1, 11, 1'b1, 1'b0);
        tick();
        chk("t2_d3_sel_b", 32'(sel_b), 32'd0);
        chk("t2_d3_sel_a", 32'(sel_a), 32'd0);

        // Load-use on $8.
        issue(1, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
        tick();
        issue(8, 2, 1'b1, 1'b1, 12, 1'b1, 1'b0);
        chk("t3_stall", 32'(stall), 32'd1);
        tick();
        chk("t3_stall_gone", 32'(stall), 32'd0);
        chk("t3_bubble", 32'(ex_bubble), 32'd1);
        chk("t3_bubble_sel_a", 32'(sel_a), 32'd0);
        chk("t3_cnt", 32'(stall_cnt), 32'd1);
        tick();
        chk("t3_sel_a", 32'(sel_a), 32'd2);
        chk("t3_sel_b", 32'(sel_b), 32'd0);
        chk("t3_bubble_off", 32'(ex_bubble), 32'd0);
        chk("t3_cnt_hold", 32'(stall_cnt), 32'd1);

        // Double producer of $4: the newer EX one wins.
        issue(1, 1, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        tick();
        issue(2, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        tick();
        issue(4, 4, 1'b1, 1'b1, 13, 1'b1, 1'b0);
        tick();
        chk("t4_sel_a", 32'(sel_a), 32'd1);
        chk("t4_sel_b", 32'(sel_b), 32'd1);
        // Register 0 never forwards or stalls, even behind a load.
        issue(1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        tick();
        issue(0, 0, 1'b1, 1'b1, 14, 1'b1, 1'b0);
        chk("t4_r0_stall", 32'(stall), 32'd0);
        tick();
        chk("t4_r0_sel_a", 32'(sel_a), 32'd0);
        chk("t4_r0_sel_b", 32'(sel_b), 32'd0);
        chk("t4_r0_bubble", 32'(ex_bubble), 32'd0);

        // Flush during a load-use hazard.
        issue(1, 0, 1'b1, 1'b0, 9, 1'b1, 1'b1);
        tick();
        issue(9, 9, 1'b1, 1'b1, 15, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("t5_stall", 32'(stall), 32'd0);
        tick();
        chk("t5_bubble", 32'(ex_bubble), 32'd1);
        chk("t5_sel_a", 32'(sel_a), 32'd0);
        chk("t5_sel_b", 32'(sel_b), 32'd0);
        chk("t5_cnt", 32'(stall_cnt), 32'd1);
        nop();
        tick();

        // Saturation: clear, then five load-use stalls on a 2-bit counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cnt_clear", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            issue(1, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
            tick();
            issue(8, 3, 1'b1, 1'b1, 12, 1'b1, 1'b0);
            chk("t6_stall", 32'(stall), 32'd1);
            tick();
            chk("t6_cnt", 32'(stall_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("t6_stall_gone", 32'(stall), 32'd0);
            tick();
        end

        // Reset with a load in EX and its dependent stalling in ID.
        issue(1, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1);
        tick();
        issue(8, 8, 1'b1, 1'b1, 12, 1'b1, 1'b0);
        chk("t6_pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_sel_a", 32'(sel_a), 32'd0);
        chk("t6_rst_sel_b", 32'(sel_b), 32'd0);
        chk("t6_rst_bubble", 32'(ex_bubble), 32'd1);
        chk("t6_rst_stall", 32'(stall), 32'd0);
        chk("t6_rst_cnt", 32'(stall_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
